// File: rtl/sram_bank_arbiter_if.sv
// Client request/response channel plus the banked SRAM bus seen by sram_bank_arbiter.
// master = clients and SRAM array side, slave = arbiter side.
interface sram_bank_arbiter_if #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned NUM_SRAMS  = 4,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 16
);
    localparam int unsigned BW = (NUM_SRAMS > 1) ? $clog2(NUM_SRAMS) : 1;

    logic [NUM_PORTS-1:0]            req_valid;
    logic [NUM_PORTS-1:0]            req_ready;
    logic [NUM_PORTS-1:0]            req_we;
    logic [NUM_PORTS*BW-1:0]         req_bank;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_PORTS-1:0]            rsp_valid;
    logic [NUM_PORTS*DATA_WIDTH-1:0] rsp_rdata;
    logic [NUM_SRAMS-1:0]            sram_en;
    logic [NUM_SRAMS-1:0]            sram_we;
    logic [NUM_SRAMS*ADDR_WIDTH-1:0] sram_addr;
    logic [NUM_SRAMS*DATA_WIDTH-1:0] sram_wdata;
    logic [NUM_SRAMS*DATA_WIDTH-1:0] sram_rdata;

    modport master (
        output req_valid, req_we, req_bank, req_addr, req_wdata, sram_rdata,
        input  req_ready, rsp_valid, rsp_rdata, sram_en, sram_we, sram_addr, sram_wdata
    );

    modport slave (
        input  req_valid, req_we, req_bank, req_addr, req_wdata, sram_rdata,
        output req_ready, rsp_valid, rsp_rdata, sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_bank_arbiter.sv
// Per-bank arbitration of NUM_PORTS clients onto NUM_SRAMS banks, with fixed-latency
// tagged read-response routing, conflict counting and out-of-range bank detection.
module sram_bank_arbiter #(
    parameter int unsigned NUM_PORTS    = 4,
    parameter int unsigned NUM_SRAMS    = 4,
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned ARB_MODE     = 1
) (
    input  logic                clk,
    input  logic                rst,
    sram_bank_arbiter_if.slave  bus,
    output logic [15:0]         conflict_cnt,
    output logic                err_bank
);
    localparam int unsigned BW = (NUM_SRAMS > 1) ? $clog2(NUM_SRAMS) : 1;
    localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef struct packed {
        logic          valid;
        logic          oob;
        logic [BW-1:0] bank;
    } rd_tag_t;

    logic [BW-1:0]        w_bank     [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_oob;
    logic [NUM_PORTS-1:0] w_ready;
    logic [NUM_SRAMS-1:0] w_bank_gnt;
    logic [PW-1:0]        w_win      [NUM_SRAMS];
    logic [PW-1:0]        w_ptr_nxt  [NUM_SRAMS];
    logic [PW-1:0]        w_port;
    int unsigned          w_idx;
    logic                 w_stall;

    logic [PW-1:0]        r_ptr      [NUM_SRAMS];
    rd_tag_t              r_pipe     [NUM_PORTS][READ_LATENCY];
    logic [15:0]          r_conflict_cnt;
    logic                 r_err_bank;

    // Unpack bank selects and flag requests aimed past the last bank.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_bank[p] = bus.req_bank[p*BW +: BW];
            w_oob[p]  = bus.req_valid[p] && (32'(w_bank[p]) >= NUM_SRAMS);
        end
    end

    // Per-bank search starting at the rotating pointer (or port 0 in fixed mode).
    always_comb begin
        w_ready    = w_oob;
        w_bank_gnt = '0;
        w_idx      = 0;
        w_port     = '0;
        for (int b = 0; b < NUM_SRAMS; b++) begin
            w_win[b]     = '0;
            w_ptr_nxt[b] = r_ptr[b];
        end
        for (int b = 0; b < NUM_SRAMS; b++) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                w_idx = (ARB_MODE == 1) ? 32'(r_ptr[b]) + 32'(k) : 32'(k);
                if (w_idx >= NUM_PORTS) w_idx = w_idx - NUM_PORTS;
                w_port = PW'(w_idx);
                if (!w_bank_gnt[b] && bus.req_valid[w_port] && !w_oob[w_port] &&
                    (32'(w_bank[w_port]) == 32'(b))) begin
                    w_bank_gnt[b]   = 1'b1;
                    w_win[b]        = w_port;
                    w_ready[w_port] = 1'b1;
                    w_ptr_nxt[b]    = (w_idx == NUM_PORTS - 1) ? '0 : PW'(w_idx + 1);
                end
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign w_stall       = |(bus.req_valid & ~w_ready);

    // Granted banks carry the winner's command; idle banks are driven to zero.
    always_comb begin
        bus.sram_en    = '0;
        bus.sram_we    = '0;
        bus.sram_addr  = '0;
        bus.sram_wdata = '0;
        for (int b = 0; b < NUM_SRAMS; b++) begin
            if (w_bank_gnt[b]) begin
                bus.sram_en[b] = 1'b1;
                bus.sram_we[b] = bus.req_we[w_win[b]];
                bus.sram_addr[b*ADDR_WIDTH +: ADDR_WIDTH] =
                    bus.req_addr[32'(w_win[b])*ADDR_WIDTH +: ADDR_WIDTH];
                bus.sram_wdata[b*DATA_WIDTH +: DATA_WIDTH] =
                    bus.req_wdata[32'(w_win[b])*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NUM_PORTS; p++)
                for (int s = 0; s < READ_LATENCY; s++)
                    r_pipe[p][s] <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_pipe[p][0] <= '{valid: w_ready[p] & ~bus.req_we[p],
                                  oob:   w_oob[p],
                                  bank:  w_bank[p]};
                for (int s = 1; s < READ_LATENCY; s++)
                    r_pipe[p][s] <= r_pipe[p][s-1];
            end
        end
    end

    // Fixed latency means the tag leaving the pipe lines up with that bank's read data.
    always_comb begin
        bus.rsp_valid = '0;
        bus.rsp_rdata = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            bus.rsp_valid[p] = r_pipe[p][READ_LATENCY-1].valid;
            if (r_pipe[p][READ_LATENCY-1].valid && !r_pipe[p][READ_LATENCY-1].oob)
                bus.rsp_rdata[p*DATA_WIDTH +: DATA_WIDTH] =
                    bus.sram_rdata[32'(r_pipe[p][READ_LATENCY-1].bank)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_conflict_cnt <= '0;
            r_err_bank     <= 1'b0;
            for (int b = 0; b < NUM_SRAMS; b++) r_ptr[b] <= '0;
        end else begin
            if (w_stall && (r_conflict_cnt != 16'hFFFF))
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            if (|w_oob)
                r_err_bank <= 1'b1;
            for (int b = 0; b < NUM_SRAMS; b++)
                r_ptr[b] <= (ARB_MODE == 1) ? w_ptr_nxt[b] : '0;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
    assign err_bank     = r_err_bank;
endmodule

// File: doc/sram_bank_arbiter.md
# sram_bank_arbiter

Parametrised multi-requester front end for the banked activation/weight SRAM array (`multi_sram`). It replaces hard-wired per-client OR-muxing with per-bank arbitration, a valid/ready request handshake and tagged read-response routing. Any number of clients (GEMM engines, element-wise unit, AXI loader/unloader) can target any bank without silent address/data collisions. It sits between the compute/DMA clients and `multi_sram`.

## Interface
Parameters:
- NUM_PORTS, 4, number of requesting clients
- NUM_SRAMS, 4, number of SRAM banks
- ADDR_WIDTH, 12, per-bank word address width
- DATA_WIDTH, 16, SRAM word width
- READ_LATENCY, 1, cycles from `sram_en` to valid `sram_rdata` (1..4)
- ARB_MODE, 1, 0 = fixed priority (lowest port wins), 1 = round robin per bank

BW below means $clog2(NUM_SRAMS), minimum 1.

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_PORTS  request present, one bit per port
- req_ready  out  NUM_PORTS  request accepted this cycle
- req_we  in  NUM_PORTS  1 = write, 0 = read
- req_bank  in  NUM_PORTS*BW  target bank per port, packed with port p at [p*BW +: BW]
- req_addr  in  NUM_PORTS*ADDR_WIDTH  word address per port
- req_wdata  in  NUM_PORTS*DATA_WIDTH  write data per port
- rsp_valid  out  NUM_PORTS  read data valid per port
- rsp_rdata  out  NUM_PORTS*DATA_WIDTH  read data per port
- sram_en / sram_we  out  NUM_SRAMS  bank enable / write enable
- sram_addr  out  NUM_SRAMS*ADDR_WIDTH  bank address
- sram_wdata  out  NUM_SRAMS*DATA_WIDTH  bank write data
- sram_rdata  in  NUM_SRAMS*DATA_WIDTH  bank read data
- conflict_cnt  out  16  saturating count of cycles with at least one stalled request
- err_bank  out  1  sticky flag: request seen with req_bank >= NUM_SRAMS

## Operation
- Each bank independently grants at most one port per cycle among the ports with `req_valid` set and `req_bank` equal to that bank.
- `req_ready[p]` is combinational from the grant. A transfer occurs when valid and ready are both high. Ungranted ports hold their request stable until granted. A requester never sees ready without valid.
- Granted bank drive: `sram_en` = 1, `sram_we` = req_we, and the port's address and data. Ungranted banks are driven with en, we, addr and wdata all 0.
- Round robin: one pointer per bank, width $clog2(NUM_PORTS). Search starts at the pointer. On a grant the pointer becomes (winner+1) mod NUM_PORTS. On no grant the pointer is unchanged.
- Fixed priority: the lowest port index wins and no pointers are used.
- Reads: each accepted read pushes {valid, bank} into a per-port READ_LATENCY-deep shift pipeline. At the output, `rsp_valid[p]` = 1 and `rsp_rdata[p]` = sram_rdata[bank].
- Writes produce no response.
- Out-of-range bank (req_bank >= NUM_SRAMS):
  - The request is accepted immediately, independent of arbitration.
  - No SRAM access is made.
  - `err_bank` is set and stays set until reset.
  - A read gets `rsp_valid` after READ_LATENCY cycles with rdata 0.
- `conflict_cnt` increments by 1 in each cycle where any valid request is not ready. It saturates at 16'hFFFF.
- Reset values: req_ready 0 until valid appears; rsp_valid 0; rsp_rdata 0; all sram_* 0; conflict_cnt 0; err_bank 0; pointers 0; pipelines cleared.

## Timing
- Request to SRAM: accept at cycle T, with `sram_en` in the same cycle T (combinational path).
- Read response: `rsp_valid` asserts at cycle T+READ_LATENCY for exactly 1 cycle per accepted read.
- Back-to-back reads from one port to one bank sustain 1 per cycle, and responses return in order.
- Different ports hitting different banks are all granted in the same cycle (full throughput).
- A port switching banks between consecutive reads still gets in-order responses, because latency is fixed.
- `rst` asserted mid-operation clears all in-flight responses: no `rsp_valid` is emitted for reads accepted before reset. Outputs are at reset values in the cycle after `rst` is sampled high.
- `rsp_rdata` for ports with `rsp_valid` = 0 is 0.

## Test plan
- Reset, then port0 writes 16'h1234 to bank2 addr 5, then reads it back -> `rsp_valid[0]` at T+READ_LATENCY with 16'h1234; conflict_cnt stays 0.
- Ports 0..3 each read a different bank in the same cycle -> all four `req_ready` high in one cycle; four responses in the same later cycle, each with its own bank's data.
- ARB_MODE=1, ports 0..3 all read bank1 continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; conflict_cnt = 8.
- ARB_MODE=0, same stimulus -> port0 granted in all 8 cycles, other ports never ready; conflict_cnt = 8.
- Port1 reads with req_bank = NUM_SRAMS -> accepted in the same cycle, no `sram_en`, err_bank = 1, rsp rdata 0.
- READ_LATENCY=3, reads accepted at cycles 10 and 11, `rst` pulsed at cycle 12 -> no `rsp_valid` afterwards; all outputs 0.
